// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode constants for the stream multiplexer
package stream_mux_pkg;
   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin request search starting at ptr, ptr moves past each granted index
module rr_arbiter #(
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            advance,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] grant_idx
);
   logic [SELW-1:0] ptr;
   // Scan from the farthest offset back to ptr so the nearest request wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            grant                         = '0;
            grant[(int'(ptr) + k) % N]    = 1'b1;
            grant_idx                     = SELW'((int'(ptr) + k) % N);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) ptr <= '0;
      else if (advance) ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
   end
endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-to-1 stream multiplexer, fixed or round-robin selection, single-entry output register
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   input  logic               mode,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_chan
);
   logic [N-1:0]     rr_grant, sel_grant, grant;
   logic [SELW-1:0]  rr_idx, chan;
   logic [WIDTH-1:0] load_data;
   logic             load_en, load;
   rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .advance   (load && mode == MODE_RR),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );
   // Out-of-range sel matches no channel, so it simply grants nothing
   always_comb begin
      sel_grant = '0;
      load_data = '0;
      for (int i = 0; i < N; i++) sel_grant[i] = (sel == SELW'(i)) && in_valid[i];
      grant    = (mode == MODE_RR) ? rr_grant : sel_grant;
      chan     = (mode == MODE_RR) ? rr_idx : sel;
      load_en  = !out_valid || out_ready;
      in_ready = grant & {N{load_en && !rst}};
      load     = |in_ready;
      for (int i = 0; i < N; i++) if (grant[i]) load_data = in_data[i*WIDTH +: WIDTH];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_chan  <= chan;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed checks of fixed/round-robin muxing, backpressure and reset
module tb_stream_mux;
   logic        clk = 1'b0;
   logic        rst, mode, out_ready, out_valid;
   logic [15:0] in_data;
   logic [3:0]  in_valid, in_ready, out_data;
   logic [1:0]  sel, out_chan;
   logic        b_rst, b_mode, b_out_ready, b_out_valid;
   logic [11:0] b_in_data;
   logic [2:0]  b_in_valid, b_in_ready;
   logic [3:0]  b_out_data;
   logic [1:0]  b_sel, b_out_chan;
   int          passed = 0, total = 0;
   always #5 clk = ~clk;
   stream_mux #(.WIDTH(4), .N(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_chan(out_chan)
   );
   stream_mux #(.WIDTH(4), .N(3)) dut3 (
      .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .sel(b_sel), .mode(b_mode), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_chan(b_out_chan)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [3:0] exp_d [5] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd5};
      logic [1:0] exp_c [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rst = 1; mode = 1; sel = 0; out_ready = 1; in_valid = 4'b1111; in_data = 16'h8765;
      b_rst = 1; b_mode = 0; b_sel = 0; b_out_ready = 1; b_in_valid = 0; b_in_data = 12'h321;
      #1;
      check("reset_in_ready", 32'(in_ready), 0);
      tick(); tick();
      check("reset_in_ready2", 32'(in_ready), 0);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_out_data", 32'(out_data), 0);
      check("reset_out_chan", 32'(out_chan), 0);
      rst = 0; mode = 0; sel = 1; in_data = 16'h0023; in_valid = 4'b0011;
      #1;
      check("sel_in_ready", 32'(in_ready), 32'b0010);
      tick();
      check("sel_out_data", 32'(out_data), 2);
      check("sel_out_chan", 32'(out_chan), 1);
      check("sel_out_valid", 32'(out_valid), 1);
      in_valid = 0;
      tick();
      check("drain_out_valid", 32'(out_valid), 0);
      check("drain_out_data_hold", 32'(out_data), 2);
      mode = 1; in_data = 16'h8765; in_valid = 4'b1111;
      #1;
      check("rr_first_grant", 32'(in_ready), 32'b0001);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("rr_data%0d", i), 32'(out_data), 32'(exp_d[i]));
         check($sformatf("rr_chan%0d", i), 32'(out_chan), 32'(exp_c[i]));
         check($sformatf("rr_valid%0d", i), 32'(out_valid), 1);
      end
      rst = 1;
      #1;
      check("midreset_in_ready", 32'(in_ready), 0);
      tick();
      check("midreset_out_valid", 32'(out_valid), 0);
      check("midreset_out_data", 32'(out_data), 0);
      rst = 0; in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("skip_chan%0d", i), 32'(out_chan), (i % 2) ? 3 : 1);
         check($sformatf("skip_data%0d", i), 32'(out_data), (i % 2) ? 8 : 6);
      end
      in_data = 16'h8769; in_valid = 4'b0001;
      tick();
      check("bp_load_data", 32'(out_data), 9);
      out_ready = 0; in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_data%0d", i), 32'(out_data), 9);
         check($sformatf("bp_chan%0d", i), 32'(out_chan), 0);
         check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 0);
         check($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
      end
      out_ready = 1;
      #1;
      check("release_in_ready", 32'(in_ready), 32'b0010);
      tick();
      check("release_data", 32'(out_data), 6);
      check("release_chan", 32'(out_chan), 1);
      b_rst = 0; b_sel = 3; b_in_valid = 3'b111;
      #1;
      check("n3_sel3_in_ready", 32'(b_in_ready), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("n3_sel3_valid%0d", i), 32'(b_out_valid), 0);
      end
      b_sel = 2; b_out_ready = 0;
      #1;
      check("n3_sel2_in_ready", 32'(b_in_ready), 32'b100);
      tick();
      check("n3_sel2_data", 32'(b_out_data), 3);
      check("n3_sel2_valid", 32'(b_out_valid), 1);
      b_rst = 1;
      #1;
      check("n3_rst_in_ready", 32'(b_in_ready), 0);
      tick();
      check("n3_rst_valid", 32'(b_out_valid), 0);
      check("n3_rst_chan", 32'(b_out_chan), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter: WIDTH, default 4, data bits per channel.
REQ-002 Parameter: N, default 4, number of input channels (N >= 2).
REQ-003 Parameter: SELW, default $clog2(N), width of sel and out_chan.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port: in_valid  in  N  per-channel data valid.
REQ-009 Port: in_ready  out  N  per-channel accept; at most one bit high.
REQ-010 Port: sel  in  SELW  channel select, used in mode 0.
REQ-011 Port: mode  in  1  0 = fixed select by sel, 1 = round-robin.
REQ-012 Port: out_data  out  WIDTH  registered output data.
REQ-013 Port: out_valid  out  1  output register holds a beat.
REQ-014 Port: out_ready  in  1  downstream accept.
REQ-015 Port: out_chan  out  SELW  source channel of the beat in out_data.

Function
REQ-016 Output is a single-entry register; latency from input handshake to out_valid SHALL be exactly 1 cycle.
REQ-017 load_en = !out_valid || out_ready; in_ready[i] SHALL be grant[i] && load_en && !rst, combinational.
REQ-018 Input transfer on channel i occurs when in_valid[i] && in_ready[i]; the register then captures that channel's data and index at the next edge.
REQ-019 Output transfer occurs when out_valid && out_ready; with no simultaneous load, out_valid SHALL clear next cycle.
REQ-020 Simultaneous output transfer and input load SHALL sustain one beat per cycle with no bubble.
REQ-021 While out_valid && !out_ready, out_data and out_chan SHALL hold and in_ready SHALL be all zero.
REQ-022 Mode 0: grant = one-hot(sel) if sel < N and in_valid[sel]; else no grant.
REQ-023 Mode 0, sel >= N (non-power-of-two N): no grant, no load, no error.
REQ-024 Mode 1: grant the first valid channel searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-025 ptr SHALL update only on an input transfer: ptr <= granted index + 1, wrapping N-1 -> 0.
REQ-026 ptr SHALL be retained across mode changes and stalls; a mode change applies to the arbitration in the same cycle it is sampled.
REQ-027 No in_valid set: no grant, ptr unchanged.
REQ-028 Data and out_chan values are don't-care-free: out_data SHALL only change on a load or reset.

Reset
REQ-029 On rst: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0, in_ready = all zero during the reset cycle.
REQ-030 Reset mid-operation SHALL discard any held beat; no beat is accepted in the reset cycle.
REQ-031 First post-reset round-robin grant SHALL favour channel 0.

Structure
REQ-032 Shared package stream_mux_pkg SHALL hold MODE_SEL = 1'b0 and MODE_RR = 1'b1 constants.
REQ-033 Round-robin search and ptr SHALL be a sub-module rr_arbiter (params N, SELW; inputs req, advance; outputs grant, grant_idx).
REQ-034 Top level holds grant muxing, load logic and the output register.

Verification (WIDTH=4, N=4 unless stated)
REQ-035 Reset: rst=1 for 2 cycles, in_valid=1111 -> in_ready=0000, out_valid=0, out_data=0, out_chan=0.
REQ-036 Mode 0: sel=1, ch0=3, ch1=2, in_valid=0011, out_ready=1 -> in_ready=0010; next cycle out_data=2, out_chan=1, out_valid=1.
REQ-037 Mode 1: in_valid=1111, ch i = i+5, out_ready=1 -> out_data 5,6,7,8,5 and out_chan 0,1,2,3,0 on consecutive cycles.
REQ-038 Mode 1 skip: in_valid=1010 after reset -> out_chan sequence 1,3,1,3.
REQ-039 Backpressure: held beat 9, out_ready=0 for 5 cycles -> out_data=9, in_ready=0000 throughout; on release next grant continues from saved ptr.
REQ-040 N=3, mode 0, sel=3, in_valid=111 -> in_ready=000, out_valid stays 0; rst asserted with out_valid=1 -> out_valid=0 next cycle.
